// File: rtl/tpu_pkg.sv
// Shared constants and FSM encoding for the TPU result drain.
// Holds tile geometry, accumulator width and the drain state type.
package tpu_pkg;

  localparam int TILE_ELEMS = 64;
  localparam int ACC_WIDTH  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TILE,
    S_READ,
    S_ACK,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/tpu_acc_bank.sv
// Tile accumulator register array: one sync write port, two comb reads.
// Ports: clk, wr_en/wr_idx/wr_data, acc_idx->acc_data, out_idx->out_data.
module tpu_acc_bank #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    acc_idx,
  output logic [WIDTH-1:0] acc_data,
  input  logic [AW-1:0]    out_idx,
  output logic [WIDTH-1:0] out_data
);
  import tpu_pkg::*;

  // Contents are never reset: tile 0 overwrites every entry before use.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign acc_data = mem[acc_idx];
  assign out_data = mem[out_idx];

endmodule

// File: rtl/tpu_result_drain.sv
// Drains K TPU tiles, sums them per element and writes the result via Avalon-MM.
// Ports: clk/resetSystem, start/k_tiles/base_addr, TPU rd_* + tile_*, avm_*, busy/all_done.
module tpu_result_drain #(
  parameter int TILE_ELEMS = tpu_pkg::TILE_ELEMS,
  parameter int ACC_WIDTH  = tpu_pkg::ACC_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetSystem,
  input  logic                  start,
  input  logic [13:0]           k_tiles,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  tile_done,
  output logic                  tile_ack,
  output logic                  rd_read,
  output logic [8:0]            rd_address,
  input  logic [ACC_WIDTH-1:0]  rd_data,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_write,
  output logic [ACC_WIDTH-1:0]  avm_writedata,
  input  logic                  avm_waitrequest,
  output logic                  busy,
  output logic                  all_done
);
  import tpu_pkg::*;

  localparam int IW = $clog2(TILE_ELEMS);
  localparam logic [IW:0]   RD_LAST = (IW+1)'(TILE_ELEMS);
  localparam logic [IW-1:0] WR_LAST = IW'(TILE_ELEMS - 1);

  state_t                state, state_nx;
  logic [13:0]           k_q;
  logic [13:0]           tile_cnt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IW:0]           rd_cnt;
  logic [IW-1:0]         wr_idx;
  logic                  skip_q;
  logic                  latch;
  logic                  acc_we;
  logic [IW-1:0]         cap_idx;
  logic [ACC_WIDTH-1:0]  acc_old;
  logic [ACC_WIDTH-1:0]  acc_new;
  logic [ACC_WIDTH-1:0]  out_word;

  // Data returns one cycle after its address, so capture lags by one.
  assign cap_idx = IW'(rd_cnt - 1'b1);
  assign acc_new = (tile_cnt == '0) ? rd_data : acc_old + rd_data;

  tpu_acc_bank #(
    .DEPTH(TILE_ELEMS),
    .WIDTH(ACC_WIDTH)
  ) u_bank (
    .clk     (clk),
    .wr_en   (acc_we),
    .wr_idx  (cap_idx),
    .wr_data (acc_new),
    .acc_idx (cap_idx),
    .acc_data(acc_old),
    .out_idx (wr_idx),
    .out_data(out_word)
  );

  always_comb begin
    state_nx      = state;
    latch         = 1'b0;
    acc_we        = 1'b0;
    tile_ack      = 1'b0;
    rd_read       = 1'b0;
    rd_address    = '0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    busy          = 1'b1;
    all_done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          latch    = 1'b1;
          state_nx = S_WAIT_TILE;
        end
      end
      S_WAIT_TILE: begin
        // skip_q masks a stale done flag still high right after ack.
        if (tile_done && !skip_q) state_nx = S_READ;
      end
      S_READ: begin
        rd_read = (rd_cnt < RD_LAST);
        if (rd_read) rd_address = 9'(rd_cnt);
        acc_we = (rd_cnt != '0);
        if (rd_cnt == RD_LAST) state_nx = S_ACK;
      end
      S_ACK: begin
        tile_ack = 1'b1;
        if (15'(tile_cnt) + 15'd1 < 15'(k_q)) state_nx = S_WAIT_TILE;
        else                                   state_nx = S_WRITE;
      end
      S_WRITE: begin
        avm_write     = 1'b1;
        avm_address   = base_q + ADDR_WIDTH'({wr_idx, 2'b00});
        avm_writedata = out_word;
        if (!avm_waitrequest && wr_idx == WR_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b0;
        all_done = 1'b1;
        if (start) begin
          latch    = 1'b1;
          state_nx = S_WAIT_TILE;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetSystem) begin
    if (resetSystem) begin
      state    <= S_IDLE;
      k_q      <= '0;
      tile_cnt <= '0;
      base_q   <= '0;
      rd_cnt   <= '0;
      wr_idx   <= '0;
      skip_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (latch) begin
        k_q      <= (k_tiles == '0) ? 14'd1 : k_tiles;
        base_q   <= base_addr;
        tile_cnt <= '0;
        skip_q   <= 1'b0;
      end
      if (state == S_READ) rd_cnt <= rd_cnt + 1'b1;
      else                 rd_cnt <= '0;
      if (state == S_WAIT_TILE) skip_q <= 1'b0;
      if (state == S_ACK) begin
        tile_cnt <= tile_cnt + 1'b1;
        skip_q   <= 1'b1;
        wr_idx   <= '0;
      end
      if (state == S_WRITE && !avm_waitrequest) wr_idx <= wr_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Directed self-checking bench for tpu_result_drain.
// Models the TPU read port and an Avalon slave with optional stall.
module tb_tpu_result_drain;
  import tpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetSystem = 1'b1;
  logic        start = 1'b0;
  logic [13:0] k_tiles = '0;
  logic [31:0] base_addr = '0;
  logic        tile_done = 1'b0;
  logic        tile_ack;
  logic        rd_read;
  logic [8:0]  rd_address;
  logic [31:0] rd_data = '0;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        busy;
  logic        all_done;

  int compared = 0;
  int mismatched = 0;

  int          mode = 0;
  int          tile_idx = 0;
  int          ack_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr [256];
  logic [31:0] wr_data [256];
  bit          stall_en = 1'b0;
  logic [31:0] stall_addr = '0;
  int          hold_cnt = 0;
  int          held = 0;
  int          cyc = 0;
  int          wstart = 0;
  int          dcyc = 0;
  bit          seen_w = 1'b0;
  bit          seen_d = 1'b0;

  tpu_result_drain #(
    .TILE_ELEMS(64),
    .ACC_WIDTH (32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk            (clk),
    .resetSystem    (resetSystem),
    .start          (start),
    .k_tiles        (k_tiles),
    .base_addr      (base_addr),
    .tile_done      (tile_done),
    .tile_ack       (tile_ack),
    .rd_read        (rd_read),
    .rd_address     (rd_address),
    .rd_data        (rd_data),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .all_done       (all_done)
  );

  always #5 clk = ~clk;

  assign avm_waitrequest = stall_en && avm_write &&
                           (avm_address == stall_addr) && (hold_cnt < 5);

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!resetSystem) begin
      if (rd_read) begin
        case (mode)
          0:       rd_data <= 32'(rd_address) + 32'd100;
          1:       rd_data <= 32'(tile_idx + 1);
          default: rd_data <= (tile_idx == 0) ? 32'h7FFF_FFFF : 32'd1;
        endcase
      end
      if (tile_ack) begin
        tile_idx = tile_idx + 1;
        ack_cnt  = ack_cnt + 1;
      end
      if (avm_write && !avm_waitrequest && wr_cnt < 256) begin
        wr_addr[wr_cnt] = avm_address;
        wr_data[wr_cnt] = avm_writedata;
        wr_cnt = wr_cnt + 1;
      end
      if (avm_waitrequest) hold_cnt = hold_cnt + 1;
      if (stall_en && avm_write && avm_address == stall_addr) held = held + 1;
      if (avm_write && !seen_w) begin
        seen_w = 1'b1;
        wstart = cyc;
      end
      if (all_done && !seen_d) begin
        seen_d = 1'b1;
        dcyc = cyc;
      end
    end
  end

  task automatic clear_rec();
    wr_cnt = 0;
    ack_cnt = 0;
    tile_idx = 0;
    hold_cnt = 0;
    held = 0;
    seen_w = 1'b0;
    seen_d = 1'b0;
  endtask

  // Launch a job and wait for all_done; start may be held into READ.
  task automatic run_job(input logic [13:0] k, input logic [31:0] base,
                         input bit hold);
    bit done;
    done = 1'b0;
    @(negedge clk);
    k_tiles = k;
    base_addr = base;
    tile_done = 1'b1;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (rd_read && rd_address == 9'd40) start = 1'b0;
      if (all_done) done = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL job_timeout: all_done=%0b required 1", all_done);
    end else begin
      compared++;
      if (busy !== 1'b0) begin
        mismatched++;
        $display("FAIL busy_in_done: got %0b required 0", busy);
      end
    end
    @(negedge clk);
    tile_done = 1'b0;
  endtask

  task automatic check_words(input logic [31:0] base, input int kind);
    logic [31:0] ea, ed;
    compared++;
    if (wr_cnt !== 64) begin
      mismatched++;
      $display("FAIL write_count: got %0d required 64", wr_cnt);
    end
    for (int i = 0; i < 64; i++) begin
      ea = base + 32'(4 * i);
      case (kind)
        0:       ed = 32'(i + 100);
        1:       ed = 32'd6;
        default: ed = 32'h8000_0000;
      endcase
      compared++;
      if (wr_addr[i] !== ea || wr_data[i] !== ed) begin
        mismatched++;
        $display("FAIL word[%0d]: got %h/%h required %h/%h",
                 i, wr_addr[i], wr_data[i], ea, ed);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    compared++;
    if ({tile_ack, rd_read, rd_address, avm_write, avm_address,
         avm_writedata, busy, all_done} !== '0) begin
      mismatched++;
      $display("FAIL %s: ack=%0b rd=%0b ra=%0d wr=%0b a=%h d=%h busy=%0b done=%0b required all 0",
               tag, tile_ack, rd_read, rd_address, avm_write, avm_address,
               avm_writedata, busy, all_done);
    end
  endtask

  task automatic test_reset();
    resetSystem = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_outputs");
    resetSystem = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_single_tile();
    clear_rec();
    mode = 0;
    run_job(14'd1, 32'h0000_1000, 1'b0);
    check_words(32'h0000_1000, 0);
    compared++;
    if (ack_cnt !== 1) begin
      mismatched++;
      $display("FAIL single_ack_count: got %0d required 1", ack_cnt);
    end
    compared++;
    if (dcyc - wstart !== 64) begin
      mismatched++;
      $display("FAIL write_latency: got %0d required 64", dcyc - wstart);
    end
  endtask

  task automatic test_accumulate();
    clear_rec();
    mode = 1;
    run_job(14'd3, 32'h0000_2000, 1'b0);
    check_words(32'h0000_2000, 1);
    compared++;
    if (ack_cnt !== 3) begin
      mismatched++;
      $display("FAIL accum_ack_count: got %0d required 3", ack_cnt);
    end
  endtask

  task automatic test_stall();
    clear_rec();
    mode = 0;
    stall_en = 1'b1;
    stall_addr = 32'h0000_3000 + 32'd40;
    run_job(14'd1, 32'h0000_3000, 1'b0);
    stall_en = 1'b0;
    check_words(32'h0000_3000, 0);
    compared++;
    if (held !== 6) begin
      mismatched++;
      $display("FAIL stall_hold: got %0d cycles required 6", held);
    end
  endtask

  task automatic test_wrap();
    clear_rec();
    mode = 2;
    run_job(14'd2, 32'hFFFF_FFF0, 1'b0);
    check_words(32'hFFFF_FFF0, 2);
    compared++;
    if (wr_addr[4] !== 32'h0000_0000) begin
      mismatched++;
      $display("FAIL addr_wrap: got %h required 00000000", wr_addr[4]);
    end
  endtask

  task automatic test_reset_mid_read();
    bit hit;
    hit = 1'b0;
    clear_rec();
    mode = 0;
    @(negedge clk);
    k_tiles = 14'd1;
    base_addr = 32'h0000_4000;
    tile_done = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (rd_read && rd_address == 9'd30) hit = 1'b1;
      else @(negedge clk);
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL reach_addr30: rd_address=%0d required 30", rd_address);
    end
    resetSystem = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("mid_read_reset");
    @(negedge clk);
    resetSystem = 1'b0;
    tile_done = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (wr_cnt !== 0 || ack_cnt !== 0) begin
      mismatched++;
      $display("FAIL abort_no_strobes: writes=%0d acks=%0d required 0/0",
               wr_cnt, ack_cnt);
    end
    clear_rec();
    run_job(14'd1, 32'h0000_5000, 1'b0);
    check_words(32'h0000_5000, 0);
  endtask

  task automatic test_start_held_k0();
    clear_rec();
    mode = 0;
    run_job(14'd0, 32'h0000_6000, 1'b1);
    check_words(32'h0000_6000, 0);
    compared++;
    if (ack_cnt !== 1) begin
      mismatched++;
      $display("FAIL k0_ack_count: got %0d required 1", ack_cnt);
    end
    @(negedge clk);
    check_idle_outputs("idle_after_k0");
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_accumulate();
    test_stall();
    test_wrap();
    test_reset_mid_read();
    test_start_held_k0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
